// File: rtl/cycle_input_capture.sv
// Input front end for the cycle computer: synchronise and debounce buttons and sensors,
// measure fork/crank periods with stall detection, accumulate trip data, decode presses.
module cycle_input_capture #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PERIOD_W        = 16,
  parameter int TOTAL_W         = 32,
  parameter int LONG_PRESS      = 320,
  parameter int STALL_LIMIT     = 65535,
  parameter int CLEAR_BTN       = 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_BUTTONS-1:0]    nButton,
  input  logic                      nFork,
  input  logic                      nCrank,
  output logic [NUM_BUTTONS*16-1:0] hold_time,
  output logic [NUM_BUTTONS-1:0]    short_press,
  output logic [NUM_BUTTONS-1:0]    long_press,
  output logic [15:0]               fork_count,
  output logic [TOTAL_W-1:0]        total_time,
  output logic [PERIOD_W-1:0]       fork_period,
  output logic [PERIOD_W-1:0]       crank_period,
  output logic                      fork_stopped,
  output logic                      crank_stopped,
  output logic                      trip_clear
);

  localparam int NCH = NUM_BUTTONS + 2;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [31:0] LP = 32'(LONG_PRESS);
  localparam logic [PERIOD_W-1:0] STALL = PERIOD_W'(STALL_LIMIT);

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                  input logic [PERIOD_W-1:0] b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + (TOTAL_W+1)'(b);
    return s[TOTAL_W] ? '1 : s[TOTAL_W-1:0];
  endfunction

  // Channel order: buttons in the low bits, then fork, then crank.
  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_sync1, r_sync2, r_db, r_db_d;
  logic [DBW-1:0] r_dbcnt [NCH];

  assign w_raw = {nCrank, nFork, nButton};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_db    <= '1;
      r_db_d  <= '1;
      for (int i = 0; i < NCH; i++) r_dbcnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]    <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
        end
      end
    end
  end

  logic [NUM_BUTTONS-1:0] w_rise;
  logic [1:0]             w_fall;
  assign w_rise = ~r_db_d[NUM_BUTTONS-1:0] & r_db[NUM_BUTTONS-1:0];
  assign w_fall = r_db_d[NCH-1:NUM_BUTTONS] & ~r_db[NCH-1:NUM_BUTTONS];

  logic [15:0]            r_hold [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] r_short, r_long;
  logic [NUM_BUTTONS-1:0] w_long_hit;
  logic                   w_others_rel;
  logic                   w_clear;

  always_comb begin
    w_others_rel = 1'b1;
    for (int j = 0; j < NUM_BUTTONS; j++) begin
      w_long_hit[j] = ~r_db[j] & ({16'd0, r_hold[j]} == LP - 32'd1);
      if (j != CLEAR_BTN && !r_db[j]) w_others_rel = 1'b0;
    end
    w_clear = w_long_hit[CLEAR_BTN] & w_others_rel;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_short <= '0;
      r_long  <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_hold[i] <= '0;
    end else begin
      r_long <= w_long_hit;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        r_short[i] <= 1'b0;
        if (r_db[i]) begin
          r_hold[i]  <= '0;
          r_short[i] <= w_rise[i] & ({16'd0, r_hold[i]} < LP);
        end else if (r_hold[i] != 16'hFFFF) begin
          r_hold[i] <= r_hold[i] + 16'd1;
        end
      end
    end
  end

  // Sensor index 0 = fork, 1 = crank.
  logic [PERIOD_W-1:0] r_pcnt   [2];
  logic [PERIOD_W-1:0] r_period [2];
  logic [1:0]          r_armed, r_stopped;
  logic [1:0]          w_armed_eff;

  // An edge landing on the stall cycle counts as a first edge, never as a period.
  always_comb begin
    for (int k = 0; k < 2; k++) w_armed_eff[k] = r_armed[k] & (r_pcnt[k] != STALL);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_armed   <= '0;
      r_stopped <= '1;
      for (int k = 0; k < 2; k++) begin
        r_pcnt[k]   <= '0;
        r_period[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_pcnt[k] == STALL) begin
          r_stopped[k] <= 1'b1;
          r_period[k]  <= '0;
          r_armed[k]   <= 1'b0;
        end
        if (w_fall[k]) begin
          r_pcnt[k] <= PERIOD_W'(1);
          if (w_armed_eff[k]) begin
            r_period[k]  <= r_pcnt[k];
            r_stopped[k] <= 1'b0;
          end else begin
            r_armed[k] <= 1'b1;
          end
        end else if (r_pcnt[k] != STALL) begin
          r_pcnt[k] <= r_pcnt[k] + 1'b1;
        end
      end
    end
  end

  logic [15:0]        r_fork_count;
  logic [TOTAL_W-1:0] r_total;
  logic               r_trip_clear;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_fork_count <= '0;
      r_total      <= '0;
      r_trip_clear <= 1'b0;
    end else begin
      r_trip_clear <= w_clear;
      if (w_clear) begin
        r_fork_count <= '0;
        r_total      <= '0;
      end else if (w_fall[0]) begin
        r_fork_count <= r_fork_count + 16'd1;
        if (w_armed_eff[0]) r_total <= sat_add(r_total, r_pcnt[0]);
      end
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_hold
    assign hold_time[g*16 +: 16] = r_hold[g];
  end

  assign short_press   = r_short;
  assign long_press    = r_long;
  assign fork_count    = r_fork_count;
  assign total_time    = r_total;
  assign fork_period   = r_period[0];
  assign crank_period  = r_period[1];
  assign fork_stopped  = r_stopped[0];
  assign crank_stopped = r_stopped[1];
  assign trip_clear    = r_trip_clear;

endmodule

// File: tb/tb_cycle_input_capture.sv
// Directed bench for cycle_input_capture: fork vector table plus hand-written button,
// trip-clear, stall and reset sequences. Stall limit shortened to keep the run short.
module tb_cycle_input_capture;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  nButton;
  logic        nFork, nCrank;
  logic [31:0] hold_time;
  logic [1:0]  short_press, long_press;
  logic [15:0] fork_count;
  logic [31:0] total_time;
  logic [15:0] fork_period, crank_period;
  logic        fork_stopped, crank_stopped, trip_clear;

  cycle_input_capture #(
    .NUM_BUTTONS(2), .DEBOUNCE_CYCLES(4), .PERIOD_W(16), .TOTAL_W(32),
    .LONG_PRESS(320), .STALL_LIMIT(3000), .CLEAR_BTN(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .nButton(nButton), .nFork(nFork), .nCrank(nCrank),
    .hold_time(hold_time), .short_press(short_press), .long_press(long_press),
    .fork_count(fork_count), .total_time(total_time), .fork_period(fork_period),
    .crank_period(crank_period), .fork_stopped(fork_stopped), .crank_stopped(crank_stopped),
    .trip_clear(trip_clear)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int sp_n [2];
  int lp_n [2];
  int tc_n;
  logic [15:0] lp_hold [2];

  initial begin
    tc_n = 0;
    for (int i = 0; i < 2; i++) begin
      sp_n[i] = 0; lp_n[i] = 0; lp_hold[i] = '0;
    end
  end

  always @(negedge HCLK) begin
    for (int i = 0; i < 2; i++) begin
      if (short_press[i]) sp_n[i]++;
      if (long_press[i]) begin
        lp_n[i]++;
        lp_hold[i] = hold_time[i*16 +: 16];
      end
    end
    if (trip_clear) tc_n++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic fork_pulse(input int w, input int g);
    nFork = 1'b0; cyc(w);
    nFork = 1'b1; cyc(g);
  endtask

  task automatic crank_pulse(input int w, input int g);
    nCrank = 1'b0; cyc(w);
    nCrank = 1'b1; cyc(g);
  endtask

  typedef struct {
    int width;
    int gap;
    int exp_count;
    int exp_period;
    int exp_total;
    bit exp_stopped;
  } fork_vec_t;

  fork_vec_t tbl [7];
  int s_sp, s_lp, s_tc;

  initial begin
    tbl[0] = '{2,   100, 0, 0,    0,    1'b1};  // glitch ignored
    tbl[1] = '{10,  990, 1, 0,    0,    1'b1};  // first edge only arms
    tbl[2] = '{10,  990, 2, 1000, 1000, 1'b0};
    tbl[3] = '{10,  990, 3, 1000, 2000, 1'b0};
    tbl[4] = '{2,   998, 3, 1000, 2000, 1'b0};  // glitch ignored
    tbl[5] = '{10,  490, 4, 2000, 4000, 1'b0};
    tbl[6] = '{10,  490, 5, 500,  4500, 1'b0};

    HRESETn = 1'b0; nButton = 2'b11; nFork = 1'b1; nCrank = 1'b1;
    cyc(3);
    chk("rst_fork_count", fork_count, 0);
    chk("rst_total", total_time, 0);
    chk("rst_periods", {fork_period, crank_period}, 0);
    chk("rst_stopped", {fork_stopped, crank_stopped}, 2'b11);
    chk("rst_pulses", {short_press, long_press, trip_clear}, 0);
    chk("rst_hold", hold_time, 0);
    HRESETn = 1'b1;
    cyc(5);

    for (int v = 0; v < 7; v++) begin
      fork_pulse(tbl[v].width, tbl[v].gap);
      chk($sformatf("vec%0d_count", v), fork_count, tbl[v].exp_count);
      chk($sformatf("vec%0d_period", v), fork_period, tbl[v].exp_period);
      chk($sformatf("vec%0d_total", v), total_time, tbl[v].exp_total);
      chk($sformatf("vec%0d_stopped", v), fork_stopped, tbl[v].exp_stopped);
    end

    // Trip button held alone: clears trip data, keeps the period.
    s_lp = lp_n[1]; s_sp = sp_n[1]; s_tc = tc_n;
    nButton = 2'b01; cyc(400);
    nButton = 2'b11; cyc(20);
    chk("trip_clear_pulse", tc_n - s_tc, 1);
    chk("trip_long_pulse", lp_n[1] - s_lp, 1);
    chk("trip_long_hold", lp_hold[1], 320);
    chk("trip_no_short", sp_n[1] - s_sp, 0);
    chk("trip_count", fork_count, 0);
    chk("trip_total", total_time, 0);
    chk("trip_period_kept", fork_period, 500);

    // Mode held with trip: no clear.
    fork_pulse(10, 490);
    chk("pre_block_count", fork_count, 1);
    s_tc = tc_n; s_lp = lp_n[1];
    nButton = 2'b00; cyc(400);
    nButton = 2'b11; cyc(20);
    chk("block_no_clear", tc_n - s_tc, 0);
    chk("block_long1", lp_n[1] - s_lp, 1);
    chk("block_count", fork_count, 1);

    // Short press on mode.
    s_sp = sp_n[0]; s_lp = lp_n[0];
    nButton = 2'b10; cyc(100);
    chk("short_hold_time", hold_time[15:0], 94);
    nButton = 2'b11; cyc(20);
    chk("short_pulse", sp_n[0] - s_sp, 1);
    chk("short_no_long", lp_n[0] - s_lp, 0);
    chk("short_hold_zero", hold_time[15:0], 0);

    // Long press on mode.
    s_sp = sp_n[0]; s_lp = lp_n[0];
    nButton = 2'b10; cyc(400);
    nButton = 2'b11; cyc(20);
    chk("long_pulse", lp_n[0] - s_lp, 1);
    chk("long_hold_at_pulse", lp_hold[0], 320);
    chk("long_no_short", sp_n[0] - s_sp, 0);

    // Fork edge registered on the same cycle as the trip clear.
    fork_pulse(10, 490);
    fork_pulse(10, 490);
    chk("sim_pre_count", fork_count, 3);
    s_tc = tc_n;
    nButton = 2'b01; cyc(319);
    nFork = 1'b0; cyc(10);
    nFork = 1'b1; cyc(71);
    nButton = 2'b11; cyc(20);
    chk("sim_clear_pulse", tc_n - s_tc, 1);
    chk("sim_count", fork_count, 0);
    chk("sim_total", total_time, 0);
    chk("sim_period", fork_period, 819);

    // Crank period and stall.
    crank_pulse(10, 490);
    chk("crank_arm_period", crank_period, 0);
    chk("crank_arm_stopped", crank_stopped, 1);
    crank_pulse(10, 490);
    crank_pulse(10, 490);
    chk("crank_period", crank_period, 500);
    chk("crank_running", crank_stopped, 0);
    cyc(3100);
    chk("crank_stall_stopped", crank_stopped, 1);
    chk("crank_stall_period", crank_period, 0);
    chk("fork_stall", {fork_stopped, fork_period}, {1'b1, 16'd0});
    crank_pulse(10, 490);
    chk("crank_rearm_period", crank_period, 0);
    chk("crank_rearm_stopped", crank_stopped, 1);
    crank_pulse(10, 490);
    chk("crank_again_period", crank_period, 500);
    chk("crank_again_stopped", crank_stopped, 0);

    // Asynchronous reset mid-count.
    for (int p = 0; p < 7; p++) fork_pulse(10, 490);
    chk("pre_reset_count", fork_count, 7);
    chk("pre_reset_period", fork_period, 500);
    cyc(100);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_count", fork_count, 0);
    chk("mid_rst_total", total_time, 0);
    chk("mid_rst_periods", {fork_period, crank_period}, 0);
    chk("mid_rst_stopped", {fork_stopped, crank_stopped}, 2'b11);
    cyc(3);
    HRESETn = 1'b1;
    cyc(5);
    fork_pulse(10, 490);
    chk("post_rst_count", fork_count, 1);
    chk("post_rst_period", fork_period, 0);
    chk("post_rst_stopped", fork_stopped, 1);
    fork_pulse(10, 490);
    chk("post_rst_period2", fork_period, 500);
    chk("post_rst_total2", total_time, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
